// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit-side arbiter.
// Imported by the arbiter and any future shared-UART consumers.
package uart_pkg;

    localparam int BYTE_W    = 8;
    localparam int GAP_CNT_W = 16;
    localparam int WD_CNT_W  = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_END,
        S_GAP
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational first-set search starting at a rotating pointer.
// Returns the first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    logic [W:0]   sum;
    logic [W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any = |req;
        idx = '0;
        sum = '0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            pos = sum[W-1:0];
            if (req[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers,
// with optional inter-frame gap and an end-of-frame watchdog.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [BYTE_W*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       en_tx,
    input  logic                       tx_d_end,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYC - 1);
    localparam logic [WD_CNT_W-1:0]  WD_LAST  = WD_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0]       ID_LAST  = IDW'(N_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic [WD_CNT_W-1:0] wd_q, wd_d;
    logic                en_tx_q;
    logic                busy_q;
    logic                err_q, err_d;
    logic                fin;
    logic                pick_any;
    logic [IDW-1:0]      pick_idx;
    logic [IDW-1:0]      grant_next;

    rr_pick #(
        .N(N_REQ)
    ) u_pick (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .any(pick_any),
        .idx(pick_idx)
    );

    assign grant_next = (grant_q == ID_LAST) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && pick_any && !rst) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // The watchdog holds cycles elapsed since en_tx, so it reads k at L+k.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        wd_d      = wd_q;
        err_d     = 1'b0;
        fin       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    tx_data_d = req_data[BYTE_W*pick_idx +: BYTE_W];
                    grant_d   = pick_idx;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d = WD_CNT_W'(1);
                if (TIMEOUT_CYC == 1) begin
                    err_d = 1'b1;
                    fin   = 1'b1;
                end else begin
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                wd_d = wd_q + 1'b1;
                if (tx_d_end) begin
                    fin = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    err_d = 1'b1;
                    fin   = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            rr_ptr_d = grant_next;
            gap_d    = '0;
            state_d  = (GAP_CYC > 0) ? S_GAP : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            gap_q     <= '0;
            wd_q      <= '0;
            en_tx_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            en_tx_q   <= (state_d == S_LAUNCH);
            busy_q    <= (state_d != S_IDLE);
            err_q     <= err_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign en_tx       = en_tx_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: one instance without gap, one with a 5-cycle gap.
module tb_uart_tx_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  a_valid, a_ready;
    logic [31:0] a_data;
    logic [7:0]  a_txd;
    logic        a_en, a_end, a_busy, a_err;
    logic [1:0]  a_gid;

    logic [3:0]  b_valid, b_ready;
    logic [31:0] b_data;
    logic [7:0]  b_txd;
    logic        b_en, b_end, b_busy, b_err;
    logic [1:0]  b_gid;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arb #(
        .N_REQ(4), .GAP_CYC(0), .TIMEOUT_CYC(20)
    ) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .tx_data(a_txd), .en_tx(a_en), .tx_d_end(a_end),
        .grant_id(a_gid), .busy(a_busy), .err_timeout(a_err)
    );

    uart_tx_arb #(
        .N_REQ(4), .GAP_CYC(5), .TIMEOUT_CYC(20)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .tx_data(b_txd), .en_tx(b_en), .tx_d_end(b_end),
        .grant_id(b_gid), .busy(b_busy), .err_timeout(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = '0;
        a_data  = 32'h13121110;
        a_end   = 1'b0;
        b_valid = '0;
        b_data  = 32'h0000BBAA;
        b_end   = 1'b0;
        tick();
        tick();

        // reset state; requests must not be acknowledged while in reset
        a_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_en", 32'(a_en), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_err", 32'(a_err), 32'h0);
        chk("rst_txd", 32'(a_txd), 32'h0);
        chk("rst_gid", 32'(a_gid), 32'h0);
        a_valid = '0;
        rst     = 1'b0;
        tick();

        // single request from requester 2
        a_data  = 32'h13A51110;
        a_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(a_ready), 32'h4);
        tick();
        a_valid = '0;
        #1;
        chk("single_en", 32'(a_en), 32'h1);
        chk("single_txd", 32'(a_txd), 32'hA5);
        chk("single_gid", 32'(a_gid), 32'h2);
        chk("single_busy", 32'(a_busy), 32'h1);
        chk("single_ready_off", 32'(a_ready), 32'h0);
        tick();
        chk("single_en_pulse", 32'(a_en), 32'h0);
        repeat (9) tick();
        a_end = 1'b1;
        tick();
        a_end = 1'b0;
        chk("single_busy_fall", 32'(a_busy), 32'h0);
        a_data = 32'h13121110;

        // spurious end in IDLE: nothing changes, pointer stays at 3
        a_end = 1'b1;
        tick();
        a_end = 1'b0;
        chk("spur_busy", 32'(a_busy), 32'h0);
        chk("spur_en", 32'(a_en), 32'h0);
        chk("spur_err", 32'(a_err), 32'h0);
        a_valid = 4'hF;
        #1;
        chk("spur_ptr", 32'(a_ready), 32'h8);
        tick();
        chk("spur_gid", 32'(a_gid), 32'h3);
        chk("spur_txd", 32'(a_txd), 32'h13);
        tick();

        // reset while waiting for end of frame
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(a_busy), 32'h0);
        chk("mrst_en", 32'(a_en), 32'h0);
        chk("mrst_txd", 32'(a_txd), 32'h0);
        chk("mrst_gid", 32'(a_gid), 32'h0);
        chk("mrst_err", 32'(a_err), 32'h0);
        rst = 1'b0;
        #1;
        chk("mrst_ptr", 32'(a_ready), 32'h1);

        // round robin over 8 frames with all requesters valid
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", 32'(a_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_en", 32'(a_en), 32'h1);
            chk("rr_gid", 32'(a_gid), 32'(k % 4));
            chk("rr_txd", 32'(a_txd), 32'(8'h10 + k % 4));
            tick();
            a_end = 1'b1;
            tick();
            a_end = 1'b0;
        end

        // watchdog: no end-of-frame for requester 1
        a_valid = 4'b0010;
        #1;
        chk("wd_ready", 32'(a_ready), 32'h2);
        tick();
        a_valid = '0;
        chk("wd_en", 32'(a_en), 32'h1);
        chk("wd_gid", 32'(a_gid), 32'h1);
        repeat (19) tick();
        chk("wd_err_early", 32'(a_err), 32'h0);
        chk("wd_busy_hold", 32'(a_busy), 32'h1);
        tick();
        chk("wd_err", 32'(a_err), 32'h1);
        chk("wd_busy_fall", 32'(a_busy), 32'h0);
        a_valid = 4'hF;
        #1;
        chk("wd_next_ready", 32'(a_ready), 32'h4);
        tick();
        a_valid = '0;
        chk("wd_err_once", 32'(a_err), 32'h0);
        chk("wd_next_gid", 32'(a_gid), 32'h2);

        // end-of-frame coinciding with watchdog expiry
        repeat (19) tick();
        a_end = 1'b1;
        tick();
        a_end = 1'b0;
        chk("simul_err", 32'(a_err), 32'h0);
        chk("simul_busy", 32'(a_busy), 32'h0);
        tick();
        chk("simul_err_late", 32'(a_err), 32'h0);
        a_valid = 4'hF;
        #1;
        chk("simul_ptr", 32'(a_ready), 32'h8);
        a_valid = '0;
        tick();

        // inter-frame gap on the second instance
        b_valid = 4'b0011;
        #1;
        chk("gap_ready0", 32'(b_ready), 32'h1);
        tick();
        chk("gap_en0", 32'(b_en), 32'h1);
        chk("gap_gid0", 32'(b_gid), 32'h0);
        chk("gap_txd0", 32'(b_txd), 32'hAA);
        tick();
        b_end = 1'b1;
        tick();
        b_end = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("gap_hold_ready", 32'(b_ready), 32'h0);
            chk("gap_hold_busy", 32'(b_busy), 32'h1);
            tick();
        end
        chk("gap_ready1", 32'(b_ready), 32'h2);
        chk("gap_busy_fall", 32'(b_busy), 32'h0);
        tick();
        chk("gap_en1", 32'(b_en), 32'h1);
        chk("gap_gid1", 32'(b_gid), 32'h1);
        chk("gap_txd1", 32'(b_txd), 32'hBB);
        b_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares the single `uart_tx` transmitter among `N_REQ` byte producers, such as the loopback path, a status reporter and a debug dumper. Each producer offers one byte at a time through a valid/ready handshake. The arbiter latches the winner's byte, pulses the transmitter start, waits for its end-of-frame pulse, and enforces an optional inter-frame gap. A watchdog recovers the arbiter if `tx_d_end` never arrives. It sits between the producers and `uart_tx`, replacing the direct `rx_d_val -> en_tx` wiring in the top level.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYC`, default 0: idle clock cycles inserted after each `tx_d_end`, 0..65535.
- `TIMEOUT_CYC`, default 65535: maximum cycles to wait for `tx_d_end` after `en_tx`, 1..2^20-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i holds a byte.
- `req_data`  in  8*N_REQ  byte of requester i, in bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot acceptance pulse; the byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_data`  out  8  byte to `uart_tx`, held stable from `en_tx` until the next acceptance.
- `en_tx`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_d_end`  in  1  one-cycle end-of-frame pulse from `uart_tx`.
- `grant_id`  out  $clog2(N_REQ)  index of the requester currently being served.
- `busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle pulse when the watchdog aborts a frame.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_END, GAP.
- **IDLE:**
  - If any `req_valid` is high, select the winner: the first valid index at or after `rr_ptr`, wrapping modulo N_REQ.
  - Assert `req_ready[winner]` combinationally in that same cycle.
  - On the clock edge: register `tx_data <= req_data[winner]` and `grant_id <= winner`, then go to LAUNCH.
- **LAUNCH:**
  - `en_tx = 1` for exactly this cycle.
  - Clear the watchdog counter and go to WAIT_END.
- **WAIT_END:**
  - Increment the watchdog each cycle.
  - On `tx_d_end`: set `rr_ptr <= grant_id + 1` (wrapping), then go to GAP if `GAP_CYC > 0`, otherwise IDLE.
  - If the watchdog reaches TIMEOUT_CYC without `tx_d_end`: pulse `err_timeout`, update `rr_ptr` the same way, and take the same next-state choice.
  - If `tx_d_end` and watchdog expiry fall in the same cycle, treat it as normal completion with no `err_timeout`.
- **GAP:** count `GAP_CYC` cycles, then go to IDLE.
- `tx_d_end` arriving in IDLE, LAUNCH or GAP is ignored and has no side effects.
- `req_ready` is never asserted outside IDLE, so at most one byte is in flight.
- A requester that drops `req_valid` before acceptance loses nothing; no byte is recorded.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,N_REQ-1,0,... A requester waits at most N_REQ-1 frames.
- Widths: gap counter is 16 bits, watchdog is 20 bits, `rr_ptr` is $clog2(N_REQ) bits with explicit wrap at N_REQ (non-power-of-two N_REQ is supported).

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `tx_data` 8'h00, `grant_id` 0, `en_tx` 0, `busy` 0, `err_timeout` 0, `req_ready` 0, both counters 0.
- Reset asserted in any state returns the block to IDLE on the next edge. An in-flight frame is abandoned and no `err_timeout` is raised.
- Acceptance in cycle T gives `en_tx` in cycle T+1 and `busy` high from T+1.
- `tx_d_end` in cycle E:
  - With GAP_CYC = 0: IDLE at E+1, so the next acceptance can happen at E+1.
  - With GAP_CYC = G: IDLE at E+1+G.
- Watchdog: if `en_tx` occurs at cycle L, `err_timeout` pulses at L+TIMEOUT_CYC, provided no `tx_d_end` arrived in cycles L+1..L+TIMEOUT_CYC.
- `en_tx`, `tx_data`, `grant_id`, `busy` and `err_timeout` are registered. `req_ready` is combinational from `req_valid`, `rr_ptr` and state.

## Structure
- Shared package `uart_pkg`: the FSM state enum (IDLE, LAUNCH, WAIT_END, GAP), the byte width constant 8, and the gap and watchdog counter widths.
- Sub-module `rr_pick`: purely combinational first-set search from a rotating pointer, parameterized by N. Inputs are `req` and `ptr`; outputs are `any` and `idx`. It is reused by future shared-RX consumers.
- The top level replaces the direct `uart_rx.rx_d_val -> uart_tx.en_tx` wiring with loopback as requester 0.

## Test plan
- **Single request:** N_REQ=4, GAP_CYC=0. `req_valid[2]` with data 8'hA5 → `req_ready[2]` pulses once, `en_tx` rises the next cycle with `tx_data`=8'hA5 and `grant_id`=2. Driving `tx_d_end` 10 cycles later → `busy` falls the next cycle.
- **Round-robin:** all four requesters hold valid with data 8'h10..8'h13 across 8 frames → grant order 0,1,2,3,0,1,2,3 and `tx_data` sequence 10,11,12,13,10,11,12,13.
- **Inter-frame gap:** GAP_CYC=5, requesters 0 and 1 valid, `tx_d_end` at cycle E → the second acceptance happens at E+6 and not earlier.
- **Watchdog:** TIMEOUT_CYC=20, `tx_d_end` never driven → `err_timeout` pulses once at 20 cycles after `en_tx`, the block returns to IDLE, and the next grant goes to `grant_id`+1.
- **Spurious and simultaneous end:**
  - `tx_d_end` pulsed in IDLE → no state change.
  - `tx_d_end` coinciding with watchdog expiry → normal completion, `err_timeout` stays 0.
- **Mid-frame reset:** `rst` asserted in WAIT_END → next cycle all outputs are at their reset values and `rr_ptr`=0. With all requesters valid, the first grant after reset goes to requester 0.
